pipe_stage_reg: RTL and testbench

Generic inter-stage pipeline register that replaces the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WR). Carries a parametrised data bundle and a parametrised control bundle between two stages using a valid/ready handshake. Supports stall by backpressure, synchronous flush, and bubble gating of control bits. An optional 2-entry skid mode breaks the combinational ready path.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and bubble gating.
// SKID=1 adds a second entry so in_ready comes from registered state only.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 96,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned SKID       = 1,
  parameter int unsigned CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_out_valid;
  logic w_in_ready;
  logic w_accept;
  logic w_pop;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  // Skid mode decouples in_ready from out_ready; single-entry mode passes it through.
  assign w_in_ready  = (SKID != 0) ? (r_state != ST_FULL) : (!w_out_valid || out_ready);
  assign w_accept    = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state   = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_accept && (SKID != 0)) begin
          w_next_state = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_next_state     = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
    if (flush) begin
      w_next_state     = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      if (CLEAR_DATA != 0) begin
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // A bubble must never present a live write enable downstream.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (CLEAR_DATA=1) and one single-entry
// instance (CLEAR_DATA=0), each with its own scoreboard queue.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 96;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    fl;
  logic [1:0]    iv;
  logic [1:0]    ir;
  logic [1:0]    ov;
  logic [1:0]    ordy;
  logic [DW-1:0] id  [2];
  logic [CW-1:0] ic  [2];
  logic [DW-1:0] od  [2];
  logic [CW-1:0] oc  [2];
  logic [1:0]    occ [2];

  logic [DW+CW-1:0] q0[$];
  logic [DW+CW-1:0] q1[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA(1)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_ctrl(ic[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLEAR_DATA(0)) u_flat (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_ctrl(ic[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]),
    .occupancy(occ[1])
  );

  task automatic chk(input string tag, input logic [DW+CW-1:0] obs, input logic [DW+CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_dut(input int k);
    logic [DW+CW-1:0] e;
    int sz;
    if (fl[k]) begin
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    if (!ov[k]) chk($sformatf("bubble_ctrl%0d", k), {{DW{1'b0}}, oc[k]}, '0);
    if (ov[k] && ordy[k]) begin
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk($sformatf("unexpected_out%0d", k), {od[k], oc[k]}, 'x);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sb_out%0d", k), {od[k], oc[k]}, e);
      end
    end
    if (iv[k] && ir[k]) begin
      if (k == 0) q0.push_back({id[k], ic[k]}); else q1.push_back({id[k], ic[k]});
    end
  endtask

  // Scoreboard sampling at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    sb_dut(0);
    sb_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    fl = '0; iv = '0; ordy = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      id[k] = '0; ic[k] = '0;
    end
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_occ%0d", k), occ[k], 0);
      chk($sformatf("rst_ctrl%0d", k), oc[k], 0);
      chk($sformatf("rst_data%0d", k), od[k], 0);
      chk($sformatf("rst_ready%0d", k), ir[k], 1);
    end

    // Single item through the skid instance
    iv[0] = 1'b1; id[0] = 96'hA5; ic[0] = 8'h03; ordy[0] = 1'b1;
    cycle();
    chk("single_valid", ov[0], 1);
    chk("single_data", od[0], 96'hA5);
    chk("single_ctrl", oc[0], 8'h03);
    iv[0] = 1'b0;
    cycle();
    chk("single_drain_valid", ov[0], 0);
    chk("single_drain_ctrl", oc[0], 0);

    // Backpressure: 1,2 accepted, 3 held upstream until space frees
    ordy[0] = 1'b0; iv[0] = 1'b1; ic[0] = 8'h10;
    id[0] = 96'd1; cycle();
    chk("bp_occ1", occ[0], 1);
    id[0] = 96'd2; cycle();
    chk("bp_occ2", occ[0], 2);
    chk("bp_ready_low", ir[0], 0);
    id[0] = 96'd3; cycle();
    chk("bp_occ_hold", occ[0], 2);
    chk("bp_head_stable", od[0], 96'd1);
    ordy[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ir[0] && iv[0]) begin
        cycle();
        iv[0] = 1'b0;
      end else begin
        cycle();
      end
    end
    chk("bp_drained", ov[0], 0);
    chk("bp_no_loss", q0.size(), 0);

    // Full throughput on both instances
    for (int i = 0; i < 16; i++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        iv[k] = 1'b1; ordy[k] = 1'b1;
        id[k] = {$urandom(), $urandom(), 32'(i)};
        ic[k] = 8'(i) ^ 8'h5A;
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tp_occ%0d_%0d", k, i), occ[k], 1);
        chk($sformatf("tp_ready%0d_%0d", k, i), ir[k], 1);
      end
    end
    iv = '0;
    cycle();
    chk("tp_empty0", q0.size(), 0);
    chk("tp_empty1", q1.size(), 0);

    // Flush while FULL with simultaneous offer and pop (skid, CLEAR_DATA=1)
    ordy[0] = 1'b0; iv[0] = 1'b1; ic[0] = 8'hC1;
    id[0] = 96'h11; cycle();
    id[0] = 96'h22; cycle();
    chk("fl_full", occ[0], 2);
    fl[0] = 1'b1; id[0] = 96'h33; ordy[0] = 1'b1;
    cycle();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("fl_valid", ov[0], 0);
    chk("fl_occ", occ[0], 0);
    chk("fl_ctrl", oc[0], 0);
    chk("fl_data_cleared", od[0], 0);
    cycle();
    chk("fl_not_stored", ov[0], 0);

    // Flush on single-entry instance, CLEAR_DATA=0 keeps data
    iv[1] = 1'b1; id[1] = 96'h44; ic[1] = 8'h7E; ordy[1] = 1'b0;
    cycle();
    fl[1] = 1'b1; id[1] = 96'h55; ordy[1] = 1'b1;
    cycle();
    fl[1] = 1'b0; iv[1] = 1'b0;
    chk("fl1_valid", ov[1], 0);
    chk("fl1_occ", occ[1], 0);
    chk("fl1_ctrl", oc[1], 0);
    chk("fl1_data_held", od[1], 96'h44);

    // Async reset between edges while FULL
    ordy[0] = 1'b0; iv[0] = 1'b1; ic[0] = 8'h0F;
    id[0] = 96'h66; cycle();
    id[0] = 96'h77; cycle();
    iv[0] = 1'b0;
    chk("ar_full", occ[0], 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid_async", ov[0], 0);
    chk("ar_occ_async", occ[0], 0);
    rst = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("ar_ready", ir[0], 1);
    cycle();

    // Single-entry stall and same-edge replacement
    iv[1] = 1'b1; id[1] = 96'h61; ic[1] = 8'h21; ordy[1] = 1'b0;
    cycle();
    chk("s0_valid", ov[1], 1);
    id[1] = 96'h62; ic[1] = 8'h22;
    #1;
    chk("s0_ready_low", ir[1], 0);
    cycle();
    chk("s0_stall_data", od[1], 96'h61);
    chk("s0_stall_ctrl", oc[1], 8'h21);
    ordy[1] = 1'b1;
    #1;
    chk("s0_ready_comb", ir[1], 1);
    cycle();
    iv[1] = 1'b0;
    chk("s0_replace_data", od[1], 96'h62);
    chk("s0_replace_valid", ov[1], 1);
    cycle();
    chk("s0_drained", ov[1], 0);
    chk("s0_no_loss", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
